// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc
// ----------------
// Reed-Solomon decoder front stage. Receives one codeword symbol per enabled
// clock (highest-degree coefficient first) and evaluates the received
// polynomial at check consecutive roots alpha^(genstart+i) with Horner's rule.
// Each accumulator has its own multiplier by a fixed root. With a constant
// operand, that multiplier reduces to an XOR network.
//
// Optional feature macro: RS_SYND_LEN_CHECK_EN
//   defined     -> a symbol counter flags codewords whose length is not n
//   not defined -> no counter, olen_err is tied to 0
//
// Ports
//   iclk      in   rising-edge clock
//   ireset_n  in   synchronous active-low reset (overrides iclkena)
//   iclkena   in   clock enable; 0 freezes every register
//   ival      in   idat valid
//   isop      in   first symbol of a codeword (qualified by ival)
//   ieop      in   last symbol of a codeword (qualified by ival)
//   idat      in   received symbol, m bits
//   oval      out  one-enabled-cycle pulse; osyn/ozero/olen_err are valid
//   osyn      out  syndrome vector, S_i in bits [i*m +: m]
//   ozero     out  every syndrome is zero
//   olen_err  out  codeword length differed from n
module rs_syndrome_calc #(
  parameter int m        = 8,
  parameter int irrpol   = 285,
  parameter int n        = 255,
  parameter int check    = 32,
  parameter int genstart = 0
) (
  input  logic               iclk,
  input  logic               ireset_n,
  input  logic               iclkena,
  input  logic               ival,
  input  logic               isop,
  input  logic               ieop,
  input  logic [m-1:0]       idat,
  output logic               oval,
  output logic [check*m-1:0] osyn,
  output logic               ozero,
  output logic               olen_err
);

  // The leading x^m term of the primitive polynomial is implicit in the shift.
  localparam logic [m-1:0] POLY = m'(irrpol);

  // Shift-and-add product in GF(2^m).
  function automatic logic [m-1:0] gf_mult(input logic [m-1:0] a,
                                           input logic [m-1:0] b);
    logic [m-1:0] p;
    logic [m-1:0] s;
    p = '0;
    s = a;
    for (int k = 0; k < m; k++) begin
      if (b[k]) p = p ^ s;
      s = {s[m-2:0], 1'b0} ^ (s[m-1] ? POLY : '0);
    end
    return p;
  endfunction

  // alpha^e by repeated multiplication by x; evaluated only at elaboration.
  function automatic logic [m-1:0] gf_alpha_pow(input int e);
    logic [m-1:0] r;
    r = m'(1);
    for (int k = 0; k < e; k++) r = gf_mult(r, m'(2));
    return r;
  endfunction

  // Reject parameter sets that cannot describe a valid RS code.
  if (n > (1 << m) - 1) begin : g_bad_n
    $error("rs_syndrome_calc: n exceeds 2^m-1");
  end
  if (check > n) begin : g_bad_check
    $error("rs_syndrome_calc: check exceeds n");
  end

  logic [check-1:0][m-1:0] r_acc;
  logic [check-1:0][m-1:0] w_acc_nxt;
  logic [check-1:0][m-1:0] r_syn;
  logic                    r_val;
  logic                    r_zero;
  logic                    w_zero_nxt;

  // Horner step per syndrome. A start-of-packet symbol replaces the old
  // accumulator, so an unterminated block is simply dropped.
  for (genvar gi = 0; gi < check; gi++) begin : g_syn
    localparam logic [m-1:0] ROOT = gf_alpha_pow((genstart + gi) % ((1 << m) - 1));
    assign w_acc_nxt[gi] = isop ? idat : (gf_mult(r_acc[gi], ROOT) ^ idat);
  end

  assign w_zero_nxt = (w_acc_nxt == '0);

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      r_acc  <= '0;
      r_syn  <= '0;
      r_val  <= 1'b0;
      r_zero <= 1'b1;
    end else if (iclkena) begin
      r_val <= ival & ieop;
      if (ival) begin
        r_acc <= w_acc_nxt;
        // The output register is separate from the accumulators, so the
        // next codeword may start right after ieop while osyn stays put.
        if (ieop) begin
          r_syn  <= w_acc_nxt;
          r_zero <= w_zero_nxt;
        end
      end
    end
  end

  assign oval  = r_val;
  assign osyn  = r_syn;
  assign ozero = r_zero;

`ifdef RS_SYND_LEN_CHECK_EN
  // The counter must be able to hold n+1, where it saturates, so that
  // overlong blocks never wrap back to a legal length.
  localparam int             CW      = $clog2(n + 2);
  localparam logic [CW-1:0]  CNT_N   = CW'(n);
  localparam logic [CW-1:0]  CNT_SAT = CW'(n + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_len_err;

  assign w_cnt_nxt = isop ? CW'(1)
                   : ((r_cnt == CNT_SAT) ? r_cnt : (r_cnt + CW'(1)));

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (iclkena && ival) begin
      r_cnt <= w_cnt_nxt;
      if (ieop) r_len_err <= (w_cnt_nxt != CNT_N);
    end
  end

  assign olen_err = r_len_err;
`else
  assign olen_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
module tb_rs_syndrome_calc;
  localparam int M   = 8;
  localparam int CHK = 32;
  localparam int N   = 255;

  logic             iclk     = 1'b0;
  logic             ireset_n = 1'b0;
  logic             iclkena  = 1'b1;
  logic             ival     = 1'b0;
  logic             isop     = 1'b0;
  logic             ieop     = 1'b0;
  logic [M-1:0]     idat     = '0;
  logic             oval;
  logic [CHK*M-1:0] osyn;
  logic             ozero;
  logic             olen_err;

  rs_syndrome_calc #(
    .m(M), .irrpol(285), .n(N), .check(CHK), .genstart(0)
  ) dut (
    .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .ival(ival),
    .isop(isop), .ieop(ieop), .idat(idat), .oval(oval), .osyn(osyn),
    .ozero(ozero), .olen_err(olen_err)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [CHK*M-1:0] syn;
    logic             zero;
    logic             len_err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // alpha^0 .. alpha^31 in GF(2^8), polynomial 0x11D, worked out by hand.
  localparam logic [7:0] A_TAB [0:31] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26,
    8'h4C, 8'h98, 8'h2D, 8'h5A, 8'hB4, 8'h75, 8'hEA, 8'hC9,
    8'h8F, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};

  logic [7:0] gexp [0:254];
  int         glog [0:255];
  logic [7:0] cw   [0:254];
  logic [7:0] blk  [0:254];
  logic       rand_en = 1'b0;
  logic       started = 1'b0;

  logic             last_en  = 1'b0;
  logic             last_rst = 1'b1;
  logic             last_eop = 1'b0;
  logic [CHK*M-1:0] held_syn = '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Syndromes of a single error of value e at polynomial degree deg.
  function automatic logic [CHK*M-1:0] syn_err(input logic [7:0] e, input int deg);
    logic [CHK*M-1:0] v;
    v = '0;
    for (int i = 0; i < CHK; i++)
      v[i*M +: M] = (e == 8'h00) ? 8'h00 : gexp[(glog[e] + i*deg) % 255];
    return v;
  endfunction

  function automatic logic [CHK*M-1:0] syn_alpha();
    logic [CHK*M-1:0] v;
    for (int i = 0; i < CHK; i++) v[i*M +: M] = A_TAB[i];
    return v;
  endfunction

  function automatic logic [CHK*M-1:0] syn_const(input logic [7:0] d);
    logic [CHK*M-1:0] v;
    for (int i = 0; i < CHK; i++) v[i*M +: M] = d;
    return v;
  endfunction

  task automatic push_exp(input logic [CHK*M-1:0] syn, input int len);
    exp_t e;
    e.syn  = syn;
    e.zero = (syn == '0);
`ifdef RS_SYND_LEN_CHECK_EN
    e.len_err = (len != N);
`else
    e.len_err = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic drive(input logic sop, input logic eop, input logic [7:0] d);
    logic en;
    do begin
      en      = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      iclkena = en;
      ival    = 1'b1;
      isop    = sop;
      ieop    = eop;
      idat    = d;
      @(posedge iclk);
      #1;
    end while (!en);
    ival    = 1'b0;
    isop    = 1'b0;
    ieop    = 1'b0;
    iclkena = 1'b1;
  endtask

  task automatic send_blk(input int len);
    for (int k = 0; k < len; k++) drive(k == 0, k == len - 1, blk[k]);
  endtask

  task automatic check_reset_state(input string tag);
    checks += 4;
    if (oval !== 1'b0) begin errors++; $display("FAIL %s oval: got %b want 0", tag, oval); end
    if (ozero !== 1'b1) begin errors++; $display("FAIL %s ozero: got %b want 1", tag, ozero); end
    if (osyn !== '0) begin errors++; $display("FAIL %s osyn: got %h want 0", tag, osyn); end
    if (olen_err !== 1'b0) begin errors++; $display("FAIL %s olen_err: got %b want 0", tag, olen_err); end
  endtask

  // Edge bookkeeping used by the monitor to tell fresh pulses from held ones.
  always @(posedge iclk) begin
    last_en  <= iclkena;
    last_rst <= !ireset_n;
    if (!ireset_n)    last_eop <= 1'b0;
    else if (iclkena) last_eop <= ival & ieop;
  end

  // Monitor / scoreboard.
  always @(negedge iclk) begin
    if (started && !last_rst) begin
      if (last_en) begin
        checks++;
        if (oval !== last_eop) begin
          errors++;
          $display("FAIL oval_timing: got %b want %b", oval, last_eop);
        end
        if (oval === 1'b1) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_oval: got pulse want none");
          end else begin
            exp_t e;
            e = sb.pop_front();
            checks += 3;
            if (osyn !== e.syn) begin
              errors++;
              $display("FAIL osyn: got %h want %h", osyn, e.syn);
            end
            if (ozero !== e.zero) begin
              errors++;
              $display("FAIL ozero: got %b want %b", ozero, e.zero);
            end
            if (olen_err !== e.len_err) begin
              errors++;
              $display("FAIL olen_err: got %b want %b", olen_err, e.len_err);
            end
          end
          held_syn = osyn;
        end
      end else if (oval === 1'b1) begin
        checks++;
        if (osyn !== held_syn) begin
          errors++;
          $display("FAIL hold_osyn: got %h want %h", osyn, held_syn);
        end
      end
    end
  end

  initial begin
    logic [7:0] g   [0:32];
    logic [7:0] par [0:31];
    logic [7:0] fb;

    // GF(2^8) exp/log tables.
    gexp[0] = 8'h01;
    for (int k = 1; k < 255; k++)
      gexp[k] = {gexp[k-1][6:0], 1'b0} ^ (gexp[k-1][7] ? 8'h1D : 8'h00);
    for (int k = 0; k < 256; k++) glog[k] = 0;
    for (int k = 0; k < 255; k++) glog[gexp[k]] = k;

    // Generator polynomial prod (x + alpha^j), j = 0..31, g[k] is coeff of x^k.
    for (int k = 0; k <= 32; k++) g[k] = 8'h00;
    g[0] = 8'h01;
    for (int j = 0; j < 32; j++) begin
      for (int k = j + 1; k >= 1; k--) g[k] = g[k-1] ^ gmul(g[k], gexp[j]);
      g[0] = gmul(g[0], gexp[j]);
    end

    // Systematic encoder: 223 message symbols then 32 parity symbols.
    for (int k = 0; k < 32; k++) par[k] = 8'h00;
    for (int k = 0; k < 223; k++) begin
      cw[k] = 8'((k * 7 + 3) & 255);
      fb = cw[k] ^ par[31];
      for (int q = 31; q >= 1; q--) par[q] = par[q-1] ^ gmul(fb, g[q]);
      par[0] = gmul(fb, g[0]);
    end
    for (int k = 0; k < 32; k++) cw[223 + k] = par[31 - k];

    // Reset.
    ireset_n = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    ireset_n = 1'b1;
    check_reset_state("reset");
    started = 1'b1;

    // Two-symbol block: r(x) = x, so S_i = alpha^i.
    push_exp(syn_alpha(), 2);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b0, 1'b1, 8'h00);

    // All-zero full codeword.
    for (int k = 0; k < N; k++) blk[k] = 8'h00;
    push_exp('0, N);
    send_blk(N);

    // Clean codeword, then the same with symbol 10 (degree 244) corrupted.
    for (int k = 0; k < N; k++) blk[k] = cw[k];
    push_exp('0, N);
    send_blk(N);
    blk[10] = cw[10] ^ 8'h5A;
    push_exp(syn_err(8'h5A, 244), N);
    send_blk(N);

    // Back-to-back blocks with random clock enable.
    rand_en = 1'b1;
    push_exp(syn_alpha(), 2);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b0, 1'b1, 8'h00);
    push_exp(syn_err(8'h5A, 2), 3);
    drive(1'b1, 1'b0, 8'h5A);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    rand_en = 1'b0;
    repeat (2) @(posedge iclk);
    #1;

    // Reset at symbol 100 of a block, then a fresh two-symbol block.
    for (int k = 0; k < 100; k++) drive(k == 0, 1'b0, cw[k]);
    ival     = 1'b1;
    idat     = cw[100];
    ireset_n = 1'b0;
    @(posedge iclk);
    #1;
    ireset_n = 1'b1;
    ival     = 1'b0;
    check_reset_state("midreset");
    push_exp(syn_alpha(), 2);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b0, 1'b1, 8'h00);

    // Length variants: 254 symbols, 255 symbols, one-symbol block.
    for (int k = 0; k < N; k++) blk[k] = 8'h00;
    push_exp('0, N - 1);
    send_blk(N - 1);
    push_exp('0, N);
    send_blk(N);
    push_exp(syn_const(8'h37), 1);
    drive(1'b1, 1'b1, 8'h37);

    // Drain: every queued expectation must have been consumed.
    repeat (5) @(posedge iclk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
